sram_bist: RTL and testbench
============================

// Module: sram_bist
// PURPOSE
//  Memory-bus initiator for the SRAM port, driving the same request side that yari drives into sram_ctrl.
//  Writes a deterministic pattern over a word range, reads it back and checks it.
//  Reads are pipelined, and at most MAX_OUT reads are in flight.
//  Used for board bring-up. It sits ahead of sram_ctrl through an external mux, selected by busy.
// PARAMETERS
//  BASE     30'h1000_0000  first word address (byte 4000_0000)
//  WORDS    262144         words tested (1 MiB); legal range 1..2^30
//  ID       2'd3           mem_id tag driven on reads; must be nonzero
//  MAX_OUT  3              max outstanding reads; legal range 1..7
// PORTS
//  clock              in   1   system clock
//  rst                in   1   synchronous, active-high reset
//  start              in   1   one-cycle pulse; starts a test when idle
//  busy               out  1   test in progress (owns memory bus)
//  done               out  1   one-cycle pulse at test completion
//  pass               out  1   high when last test saw zero errors; held until next start
//  errors             out  16  mismatch count, saturating at 16'hFFFF
//  fail_address       out  30  word address of first mismatch
//  fail_expected      out  32  expected data of first mismatch
//  fail_actual        out  32  read data of first mismatch
//  mem_waitrequest    in   1   request stalled this cycle
//  mem_id             out  2   request tag (ID on reads, 0 on writes)
//  mem_address        out  30  word address
//  mem_read           out  1   read request
//  mem_write          out  1   write request
//  mem_writedata      out  32  write data
//  mem_writedatamask  out  4   byte enables; always 4'hF
//  mem_readdata       in   32  read data, valid when mem_readdataid==ID
//  mem_readdataid     in   2   response tag; 0 = no response
// BEHAVIOUR
//  Reset and idle outputs:
//  - All outputs are 0 after reset, except mem_writedatamask = 4'hF; pass = 0.
//  - A reset mid-test returns to IDLE at once with no drain. Stale ID responses are ignored in IDLE.
//  Pattern: P(i) = {i[15:0]^16'hA5A5, ~i[15:0]}, where i = word index 0..WORDS-1 and address = BASE+i.
//  Handshake:
//  - A request is accepted in a cycle where (mem_read|mem_write) & ~mem_waitrequest.
//  - While stalled, mem_address, mem_writedata, mem_read and mem_write are held stable.
//  - mem_read and mem_write are never both high.
//  Responses:
//  - Responses arrive in issue order, one per cycle at most.
//  - A response with mem_readdataid != ID is ignored (shared bus).
//  FSM: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
//  - IDLE: on start, clear errors and pass, set busy next cycle, enter WRITE with i=0. start while busy is ignored.
//  - WRITE: drive P(i) at BASE+i. On acceptance, i++. After acceptance of i=WORDS-1, enter READ with i=0.
//  - READ: issue a read at BASE+i when outstanding < MAX_OUT. A response in the same cycle frees a slot.
//    On acceptance, i++ and outstanding++. After the last accept, enter DRAIN.
//  - Check: a separate counter c gives the expected index.
//    Each response compares against P(c), then c++ and outstanding--.
//    On mismatch: errors++ (saturating). If this is the first mismatch, latch fail_address/_expected/_actual.
//    Accept and response in the same cycle leave outstanding unchanged.
//  - DRAIN: wait until outstanding == 0 (c == WORDS).
//  - DONE: done=1 for one cycle, pass = (errors==0), busy=0, then IDLE.
//  Counters:
//  - i and c are 30-bit; address arithmetic wraps mod 2^30.
//  - outstanding is 3-bit and can never exceed MAX_OUT.
//  Latency: a stall-free WORDS=N run with 1-cycle read latency completes in about 2N+MAX_OUT+3 cycles.
// CONFIGURATION
//  SRAM_BIST_INVERT_PASS_EN:
//  - Defined: after DRAIN, repeat WRITE/READ/DRAIN once with ~P(i), then DONE.
//    fail_* reports the first mismatch over both passes.
//  - Undefined: single pass only, and no extra logic.
// STRUCTURE
//  Shared package/header holds:
//  - state encodings S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
//  - the ID_NONE=2'd0 constant
//  - the pattern function P
//  One sub-module, sram_bist_checker: the c counter, the compare, and the error/first-fail latches.
// TESTING
//  1. Ideal memory model, WORDS=16, no waitrequest, latency 1: done after 1 pulse, pass=1, errors=0, 16 writes then 16 reads.
//  2. Model flips bit 0 of word 5 on read: pass=0, errors=1, fail_address=BASE+5, fail_expected=32'hA5A0FFFA, fail_actual=32'hA5A0FFFB.
//  3. Random waitrequest at 50% plus latency 4: outstanding never exceeds 3, addresses held while stalled, pass=1.
//  4. Foreign responses with id=1 interleaved: ignored, errors=0.
//  5. rst asserted during READ: next cycle busy=0, mem_read=0. A later start runs clean with pass=1.
//  6. start pulsed while busy: no restart; exactly one done pulse.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared definitions for the SRAM built-in self test: FSM encodings, tag constants, test pattern.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package sram_bist_pkg;

    // FSM encodings
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Response tag meaning "no response this cycle"; also the tag driven on writes
    localparam logic [1:0] ID_NONE  = 2'd0;
    localparam logic [3:0] MASK_ALL = 4'hF;

    // Test word for index i: only the low 16 bits of the index shape the pattern
    function automatic logic [31:0] bist_pattern(input logic [15:0] idx_lo);
        return {idx_lo ^ 16'hA5A5, ~idx_lo};
    endfunction

endpackage

// File: rtl/sram_bist_if.sv
// SRAM request/response bus between an initiator (BIST, cpu) and the SRAM controller.
// Latency: n/a (wires only).
// Backpressure: mem_waitrequest stalls the initiator; requests must be held while stalled.
// Ports: mem_id/address/read/write/writedata/writedatamask flow initiator->target,
//        mem_waitrequest/readdata/readdataid flow target->initiator.
interface sram_bist_if;
    logic        mem_waitrequest;
    logic [1:0]  mem_id;
    logic [29:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_writedatamask;
    logic [31:0] mem_readdata;
    logic [1:0]  mem_readdataid;

    modport master (
        input  mem_waitrequest, mem_readdata, mem_readdataid,
        output mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
    );

    modport slave (
        output mem_waitrequest, mem_readdata, mem_readdataid,
        input  mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
    );
endinterface

// File: rtl/sram_bist_checker.sv
// Read-back checker: tracks the expected word index, compares responses, counts errors, latches first fail.
// Latency: results registered one cycle after the response is presented.
// Backpressure: none; every valid response is consumed in the cycle it arrives.
// Ports: clk_i/rst_i; clear_i (new test), restart_i (new pass, index back to 0), inv_i (pattern inverted),
//        rsp_vld_i/rsp_dat_i (accepted read response); errors_o and fail_* results.
module sram_bist_checker
    import sram_bist_pkg::*;
#(
    parameter logic [29:0] BASE = 30'h1000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        restart_i,
    input  logic        inv_i,
    input  logic        rsp_vld_i,
    input  logic [31:0] rsp_dat_i,
    output logic [15:0] errors_o,
    output logic [29:0] fail_address_o,
    output logic [31:0] fail_expected_o,
    output logic [31:0] fail_actual_o
);

    logic [29:0] cnt_q, cnt_d;
    logic [15:0] errors_q, errors_d;
    logic [29:0] fail_addr_q, fail_addr_d;
    logic [31:0] fail_exp_q, fail_exp_d;
    logic [31:0] fail_act_q, fail_act_d;
    logic [31:0] exp_w;
    logic        mismatch;

    assign exp_w    = bist_pattern(cnt_q[15:0]) ^ {32{inv_i}};
    assign mismatch = rsp_vld_i && (rsp_dat_i != exp_w);

    always_comb begin
        cnt_d       = cnt_q;
        errors_d    = errors_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;
        if (clear_i) begin
            cnt_d       = '0;
            errors_d    = '0;
            fail_addr_d = '0;
            fail_exp_d  = '0;
            fail_act_d  = '0;
        end else begin
            if (restart_i) begin
                cnt_d = '0;
            end
            if (rsp_vld_i) begin
                cnt_d = cnt_q + 30'd1;
            end
            if (mismatch) begin
                if (errors_q != 16'hFFFF) begin
                    errors_d = errors_q + 16'd1;
                end
                // errors never wraps back to zero, so zero means no mismatch seen yet
                if (errors_q == 16'd0) begin
                    fail_addr_d = BASE + cnt_q;
                    fail_exp_d  = exp_w;
                    fail_act_d  = rsp_dat_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            errors_q    <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            errors_q    <= errors_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
        end
    end

    assign errors_o        = errors_q;
    assign fail_address_o  = fail_addr_q;
    assign fail_expected_o = fail_exp_q;
    assign fail_actual_o   = fail_act_q;

endmodule

// File: rtl/sram_bist.sv
// SRAM BIST initiator: writes a pattern over BASE..BASE+WORDS-1, reads it back pipelined, reports result.
// Latency: about 2*WORDS+MAX_OUT+3 cycles start->done with no stalls and 1-cycle read latency.
// Backpressure: honours mem_waitrequest (request held stable); at most MAX_OUT reads in flight.
// Ports: clk_i/rst_i (sync active-high), start_i, busy_o, done_o, pass_o, errors_o, fail_*_o, bus (master).
// Option: SRAM_BIST_INVERT_PASS_EN adds a second write/read pass using the inverted pattern.
module sram_bist
    import sram_bist_pkg::*;
#(
    parameter logic [29:0] BASE    = 30'h1000_0000,
    parameter int unsigned WORDS   = 262144,
    parameter logic [1:0]  ID      = 2'd3,
    parameter int unsigned MAX_OUT = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          pass_o,
    output logic [15:0]   errors_o,
    output logic [29:0]   fail_address_o,
    output logic [31:0]   fail_expected_o,
    output logic [31:0]   fail_actual_o,
    sram_bist_if.master   bus
);

    localparam logic [29:0] LAST_IDX = 30'(WORDS - 1);
    localparam logic [2:0]  OUT_MAX  = 3'(MAX_OUT);

    logic [2:0]  state_q, state_d;
    logic [29:0] idx_q, idx_d;
    logic [2:0]  out_q, out_d;
    logic        pass_q, pass_d;
    logic        inv_q;
`ifdef SRAM_BIST_INVERT_PASS_EN
    logic        inv_d;
`else
    assign inv_q = 1'b0;
`endif

    logic        rsp_vld;
    logic        rd_req;
    logic        wr_req;
    logic        accept;
    logic        rd_acc;
    logic        chk_clear;
    logic        chk_restart;
    logic [15:0] errors_w;

    // Only count our own tag, and only while reads can be outstanding; stale
    // responses after an aborted test are dropped here.
    assign rsp_vld = (bus.mem_readdataid == ID) &&
                     ((state_q == S_READ) || (state_q == S_DRAIN)) &&
                     (out_q != 3'd0);

    // A response this cycle frees a slot, so a full window can still issue.
    // While stalled the window can only shrink, so a raised read stays raised.
    assign rd_req = (state_q == S_READ) && ((out_q < OUT_MAX) || rsp_vld);
    assign wr_req = (state_q == S_WRITE);
    assign accept = (rd_req || wr_req) && !bus.mem_waitrequest;
    assign rd_acc = rd_req && !bus.mem_waitrequest;

    assign bus.mem_read          = rd_req;
    assign bus.mem_write         = wr_req;
    assign bus.mem_id            = rd_req ? ID : ID_NONE;
    assign bus.mem_address       = (rd_req || wr_req) ? (BASE + idx_q) : '0;
    assign bus.mem_writedata     = wr_req ? (bist_pattern(idx_q[15:0]) ^ {32{inv_q}}) : '0;
    assign bus.mem_writedatamask = MASK_ALL;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_d       = out_q;
        pass_d      = pass_q;
`ifdef SRAM_BIST_INVERT_PASS_EN
        inv_d       = inv_q;
`endif
        chk_clear   = 1'b0;
        chk_restart = 1'b0;

        if (rd_acc && !rsp_vld) begin
            out_d = out_q + 3'd1;
        end else if (!rd_acc && rsp_vld) begin
            out_d = out_q - 3'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_WRITE;
                    idx_d     = '0;
                    pass_d    = 1'b0;
                    chk_clear = 1'b1;
`ifdef SRAM_BIST_INVERT_PASS_EN
                    inv_d     = 1'b0;
`endif
                end
            end
            S_WRITE: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_READ;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 30'd1;
                    end
                end
            end
            S_READ: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 30'd1;
                    end
                end
            end
            S_DRAIN: begin
                // out_q==0 implies no response is counted this cycle, so errors is final
                if (out_q == 3'd0) begin
`ifdef SRAM_BIST_INVERT_PASS_EN
                    if (!inv_q) begin
                        state_d     = S_WRITE;
                        idx_d       = '0;
                        inv_d       = 1'b1;
                        chk_restart = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        pass_d  = (errors_w == 16'd0);
                    end
`else
                    state_d = S_DONE;
                    pass_d  = (errors_w == 16'd0);
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            out_q   <= '0;
            pass_q  <= 1'b0;
`ifdef SRAM_BIST_INVERT_PASS_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            pass_q  <= pass_d;
`ifdef SRAM_BIST_INVERT_PASS_EN
            inv_q   <= inv_d;
`endif
        end
    end

    sram_bist_checker #(
        .BASE (BASE)
    ) u_checker (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .clear_i         (chk_clear),
        .restart_i       (chk_restart),
        .inv_i           (inv_q),
        .rsp_vld_i       (rsp_vld),
        .rsp_dat_i       (bus.mem_readdata),
        .errors_o        (errors_w),
        .fail_address_o  (fail_address_o),
        .fail_expected_o (fail_expected_o),
        .fail_actual_o   (fail_actual_o)
    );

    assign errors_o = errors_w;
    assign busy_o   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o   = (state_q == S_DONE);
    assign pass_o   = pass_q;

endmodule

// File: tb/tb_sram_bist.sv
// Testbench for sram_bist: behavioural SRAM with random stalls, latency, foreign tags and fault injection.
// Latency: model returns reads after a configurable number of cycles, in order, one per cycle.
// Backpressure: random mem_waitrequest when enabled.
module tb_sram_bist;

    localparam logic [29:0] BASE    = 30'h1000_0000;
    localparam int          WORDS   = 16;
    localparam logic [1:0]  ID      = 2'd3;
    localparam int          MAX_OUT = 3;
`ifdef SRAM_BIST_INVERT_PASS_EN
    localparam int          PASSES  = 2;
`else
    localparam int          PASSES  = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy_o, done_o, pass_o;
    logic [15:0] errors_o;
    logic [29:0] fail_address_o;
    logic [31:0] fail_expected_o, fail_actual_o;

    sram_bist_if bus();

    sram_bist #(
        .BASE    (BASE),
        .WORDS   (WORDS),
        .ID      (ID),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .pass_o          (pass_o),
        .errors_o        (errors_o),
        .fail_address_o  (fail_address_o),
        .fail_expected_o (fail_expected_o),
        .fail_actual_o   (fail_actual_o),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Expected word for index idx in pass number phase (second pass is inverted)
    function automatic logic [31:0] ref_word(input int idx, input int phase);
        logic [15:0] lo;
        lo = idx[15:0];
        return {lo ^ 16'hA5A5, ~lo} ^ ((phase != 0) ? 32'hFFFF_FFFF : 32'h0);
    endfunction

    // ---------------- behavioural memory / bus monitor ----------------
    typedef struct {
        logic [31:0] dat;
        int          due;
    } rsp_t;

    logic [31:0] mem [logic [29:0]];
    rsp_t        rq[$];
    int          cyc = 0;
    int          lat = 1;
    bit          wait_en = 0, foreign_en = 0, corrupt_en = 0;
    int          wr_cnt = 0, rd_cnt = 0, seq_bad = 0, hold_bad = 0, excl_bad = 0;
    int          out_model = 0, max_out = 0, done_cnt = 0;
    bit          drove_own;
    bit          stalled_prev = 0;
    logic [29:0] p_addr;
    logic [31:0] p_wdat;
    logic        p_rd, p_wr;
    logic [31:0] rd_dat;

    initial begin
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = '0;
        bus.mem_readdataid  = 2'd0;
        forever begin
            @(negedge clk);
            cyc++;
            drove_own = 0;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                bus.mem_readdataid = ID;
                bus.mem_readdata   = rq[0].dat;
                void'(rq.pop_front());
                drove_own = 1;
            end else if (foreign_en && $urandom_range(0, 2) == 0) begin
                bus.mem_readdataid = 2'd1;
                bus.mem_readdata   = $urandom;
            end else begin
                bus.mem_readdataid = 2'd0;
                bus.mem_readdata   = $urandom;
            end
            bus.mem_waitrequest = wait_en ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (rst) begin
                stalled_prev = 0;
                out_model    = 0;
            end else begin
                if (bus.mem_read && bus.mem_write) excl_bad++;
                if (stalled_prev && (bus.mem_address != p_addr || bus.mem_writedata != p_wdat ||
                                     bus.mem_read != p_rd || bus.mem_write != p_wr)) hold_bad++;
                stalled_prev = (bus.mem_read || bus.mem_write) && bus.mem_waitrequest;
                p_addr = bus.mem_address;
                p_wdat = bus.mem_writedata;
                p_rd   = bus.mem_read;
                p_wr   = bus.mem_write;
                if ((bus.mem_read || bus.mem_write) && !bus.mem_waitrequest) begin
                    if (bus.mem_write) begin
                        if (bus.mem_address != BASE + 30'(wr_cnt % WORDS) ||
                            bus.mem_writedata != ref_word(wr_cnt % WORDS, wr_cnt / WORDS) ||
                            bus.mem_id != 2'd0 || bus.mem_writedatamask != 4'hF) seq_bad++;
                        mem[bus.mem_address] = bus.mem_writedata;
                        wr_cnt++;
                    end else begin
                        if (bus.mem_address != BASE + 30'(rd_cnt % WORDS) || bus.mem_id != ID ||
                            wr_cnt != WORDS * (rd_cnt / WORDS + 1)) seq_bad++;
                        rd_dat = mem.exists(bus.mem_address) ? mem[bus.mem_address] : 32'hDEAD_BEEF;
                        if (corrupt_en && bus.mem_address == BASE + 30'd5) rd_dat = rd_dat ^ 32'h1;
                        rq.push_back('{rd_dat, cyc + lat});
                        rd_cnt++;
                        out_model++;
                    end
                end
                if (drove_own && busy_o && out_model > 0) out_model--;
                if (out_model > max_out) max_out = out_model;
                if (done_o) done_cnt++;
            end
        end
    end

    // ---------------- test sequences ----------------
    task automatic clear_stats(input int l, input bit w, input bit f, input bit c);
        lat = l; wait_en = w; foreign_en = f; corrupt_en = c;
        wr_cnt = 0; rd_cnt = 0; seq_bad = 0; hold_bad = 0; excl_bad = 0; max_out = 0;
        mem.delete();
    endtask

    task automatic run_test(input string name, input int l, input bit w, input bit f,
                            input bit c, input bit midstart);
        int d0;
        bit got;
        @(negedge clk);
        clear_stats(l, w, f, c);
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            #2;
            start = (midstart && (k == 10 || k == 25)) ? 1'b1 : 1'b0;
            if (done_cnt != d0) got = 1;
        end
        start = 1'b0;
        chk({name, ".done_seen"}, 32'(got), 32'd1);
        repeat (20) @(negedge clk);
        #2;
        chk({name, ".done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({name, ".busy_after"}, 32'(busy_o), 32'd0);
        chk({name, ".pass"}, 32'(pass_o), c ? 32'd0 : 32'd1);
        chk({name, ".errors"}, 32'(errors_o), c ? 32'(PASSES) : 32'd0);
        if (c) begin
            chk({name, ".fail_address"}, 32'(fail_address_o), 32'(BASE + 30'd5));
            chk({name, ".fail_expected"}, fail_expected_o, 32'hA5A0FFFA);
            chk({name, ".fail_actual"}, fail_actual_o, 32'hA5A0FFFB);
        end
        chk({name, ".writes"}, 32'(wr_cnt), 32'(WORDS * PASSES));
        chk({name, ".reads"}, 32'(rd_cnt), 32'(WORDS * PASSES));
        chk({name, ".sequence"}, 32'(seq_bad), 32'd0);
        chk({name, ".hold"}, 32'(hold_bad), 32'd0);
        chk({name, ".rd_wr_excl"}, 32'(excl_bad), 32'd0);
        chk({name, ".max_outstanding"}, 32'(max_out <= MAX_OUT), 32'd1);
    endtask

    initial begin
        bit got;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("reset.busy", 32'(busy_o), 32'd0);
        chk("reset.done", 32'(done_o), 32'd0);
        chk("reset.pass", 32'(pass_o), 32'd0);
        chk("reset.errors", 32'(errors_o), 32'd0);
        chk("reset.fail_address", 32'(fail_address_o), 32'd0);
        chk("reset.rw", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("reset.address", 32'(bus.mem_address), 32'd0);
        chk("reset.id", 32'(bus.mem_id), 32'd0);
        chk("reset.mask", 32'(bus.mem_writedatamask), 32'hF);
        rst = 1'b0;

        run_test("ideal",   1, 0, 0, 0, 0);
        run_test("flip5",   1, 0, 0, 1, 0);
        run_test("stall",   4, 1, 0, 0, 0);
        run_test("foreign", 2, 1, 1, 0, 0);

        // reset in the middle of the read phase
        @(negedge clk);
        clear_stats(1, 0, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int k = 0; k < 500 && !got; k++) begin
            @(negedge clk);
            #2;
            if (rd_cnt >= 4) got = 1;
        end
        chk("midrst.reached_read", 32'(got), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("midrst.busy", 32'(busy_o), 32'd0);
        chk("midrst.read", 32'(bus.mem_read), 32'd0);
        chk("midrst.errors", 32'(errors_o), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run_test("after_rst", 1, 0, 0, 0, 0);

        run_test("restart", 1, 1, 0, 0, 1);

        for (int r = 0; r < 4; r++) begin
            run_test("random", $urandom_range(1, 5), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, err_cnt);
        $finish;
    end

endmodule
